fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the decode/control unit: owns the PC, runs a req/ack handshake
//  to instruction memory, and drives the IF/ID pipeline register (instr, pc, pc+4, valid).

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_if_id_reg.sv | 74 +++++++
 rtl/fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_fetch_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types, defaults and PC helpers
//
// Purpose: state encoding for the fetch FSM, reset defaults, the PC increment
//          and word-alignment helper used by fetch_stage and its IF/ID register.
// Ports:   none (package).

package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Redirect targets are always word aligned; low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with clear/hold/load priority
//
// Purpose: holds instr, pc, pc+4 and valid for the decode stage.
//          Priority is clear > hold > load; with no control asserted it keeps its value.
//          Clear turns the slot into a bubble (valid=0, instr=NOP) and leaves pc/pc4 as they were.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             make the slot a bubble
//   hold_i              keep current contents
//   load_i              capture instr_i/pc_i/pc4_i as a valid instruction
//   instr_i/pc_i/pc4_i  data to load
//   instr_o/pc_o/pc4_o  registered IF/ID contents
//   valid_o             1 = real instruction

module fetch_stage_if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (clear_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (hold_i) begin
            instr_d = instr_q;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ack, IF/ID register
//
// Purpose: owns the PC, fetches one word per ack from instruction memory and
//          feeds the IF/ID register. Stall holds PC and IF/ID; flush redirects
//          and kills both IF/ID and any in-flight fetch. Flush beats stall.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall              decode cannot accept; hold PC and IF/ID
//   flush              redirect to branch_target (low two bits ignored)
//   branch_target      redirect address, sampled with flush
//   imem_req/addr      fetch request and word address (decoded from state/PC)
//   imem_rdata/ack     returned word and one-cycle completion
//   if_id_instr/pc/pc4/valid  registered IF/ID contents

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;            // redirect target waiting for the dropped fetch to finish
    logic [31:0]  skid_instr_q, skid_instr_d; // word acked while decode was stalled
    logic [31:0]  skid_pc_q, skid_pc_d;

    logic         ifid_clear;
    logic         ifid_hold;
    logic         ifid_load;
    logic [31:0]  load_instr;
    logic [31:0]  load_pc;
    logic [31:0]  target;

    assign target = align_word(branch_target);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_clear   = 1'b0;
        ifid_hold    = 1'b0;
        ifid_load    = 1'b0;
        load_instr   = imem_rdata;
        load_pc      = pc_q;

        case (state_q)
            S_IDLE: begin
                // Single post-reset cycle; a redirect here only retargets the first fetch.
                ifid_clear = 1'b1;
                state_d    = S_FETCH;
                if (flush) begin
                    pc_d = target;
                end
            end

            S_FETCH: begin
                if (flush) begin
                    ifid_clear   = 1'b1;
                    skid_instr_d = 32'h0000_0000;
                    skid_pc_d    = 32'h0000_0000;
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        // Request is still open and addr must stay stable: drain it first.
                        pend_d  = target;
                        state_d = S_DROP;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        // Word arrived but decode is blocked: park it so it is neither lost nor refetched.
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        ifid_hold    = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + PC_INC;
                    end
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_clear = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    ifid_clear   = 1'b1;
                    skid_instr_d = 32'h0000_0000;
                    skid_pc_d    = 32'h0000_0000;
                    pc_d         = target;
                    state_d      = S_FETCH;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_load  = 1'b1;
                    load_instr = skid_instr_q;
                    load_pc    = skid_pc_q;
                    pc_d       = pc_q + PC_INC;
                    state_d    = S_FETCH;
                end
            end

            S_DROP: begin
                ifid_clear = 1'b1;
                if (imem_ack) begin
                    // A flush arriving with the ack is the newest redirect and wins.
                    pc_d    = flush ? target : pend_q;
                    state_d = S_FETCH;
                end else if (flush) begin
                    pend_d = target;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0000_0000;
            skid_instr_q <= 32'h0000_0000;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // During S_DROP pc_q still holds the abandoned address, keeping imem_addr stable until ack.
    assign imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
    assign imem_addr = pc_q;

    fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (ifid_clear),
        .hold_i  (ifid_hold),
        .load_i  (ifid_load),
        .instr_i (load_instr),
        .pc_i    (load_pc),
        .pc4_i   (load_pc + PC_INC),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the fetcher is either starting up, waiting out a killed fetch,
    // sitting on a parked word, or fetching normally at m_pc.
    bit          m_starting;
    bit          m_killing;
    bit          m_parked;
    logic [31:0] m_pc;
    logic [31:0] m_redirect;
    logic [31:0] m_park_word;
    logic [31:0] m_park_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'hE000_0000;
    endfunction

    function automatic bit req_expected();
        return !m_starting && !m_parked;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, req_expected()});
        chk({tag, ".addr"},  imem_addr,            m_pc);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
        chk({tag, ".instr"}, if_id_instr,          e_instr);
        chk({tag, ".pc"},    if_id_pc,             e_pc);
        chk({tag, ".pc4"},   if_id_pc4,            e_pc4);
    endtask

    task automatic model_reset();
        m_starting  = 1'b1;
        m_killing   = 1'b0;
        m_parked    = 1'b0;
        m_pc        = RST_PC;
        m_redirect  = 32'h0;
        m_park_word = 32'h0;
        m_park_pc   = 32'h0;
        e_valid     = 1'b0;
        e_instr     = NOP;
        e_pc        = 32'h0;
        e_pc4       = 32'h0;
    endtask

    task automatic bubble();
        e_valid = 1'b0;
        e_instr = NOP;
    endtask

    task automatic deliver(input logic [31:0] word, input logic [31:0] addr);
        e_valid = 1'b1;
        e_instr = word;
        e_pc    = addr;
        e_pc4   = addr + 32'd4;
    endtask

    task automatic step(input string tag, input logic st, input logic fl,
                        input logic [31:0] tg, input logic ak, input logic [31:0] rd);
        logic [31:0] tgt;
        stall         = st;
        flush         = fl;
        branch_target = tg;
        imem_ack      = ak;
        imem_rdata    = rd;
        tgt = tg & 32'hFFFF_FFFC;
        if (m_starting) begin
            m_starting = 1'b0;
            if (fl) m_pc = tgt;
            bubble();
        end else if (m_parked) begin
            if (fl) begin
                m_parked = 1'b0;
                m_pc     = tgt;
                bubble();
            end else if (!st) begin
                deliver(m_park_word, m_park_pc);
                m_pc     = m_pc + 32'd4;
                m_parked = 1'b0;
            end
        end else if (m_killing) begin
            bubble();
            if (ak) begin
                m_killing = 1'b0;
                m_pc      = fl ? tgt : m_redirect;
            end else if (fl) begin
                m_redirect = tgt;
            end
        end else begin
            if (fl) begin
                bubble();
                if (ak) m_pc = tgt;
                else begin
                    m_killing  = 1'b1;
                    m_redirect = tgt;
                end
            end else if (ak) begin
                if (st) begin
                    m_parked    = 1'b1;
                    m_park_word = rd;
                    m_park_pc   = m_pc;
                end else begin
                    deliver(rd, m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end else if (!st) begin
                bubble();
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_step();
        logic st, fl, ak;
        st = ($urandom_range(0, 3) == 0);
        fl = ($urandom_range(0, 9) == 0);
        ak = req_expected() && ($urandom_range(0, 9) < 6);
        step("rand", st, fl, $urandom, ak, mem_word(m_pc));
    endtask

    initial begin
        // 6a: reset state with clocks running
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        #1;
        check_all("idle");

        // 1: continuous ack, addresses 0,4,8,C
        step("t1_idle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1_first_addr", imem_addr, RST_PC);
        for (int i = 0; i < 4; i++) begin
            step("t1_ack", 1'b0, 1'b0, 32'h0, 1'b1, mem_word(m_pc));
        end
        chk("t1_last_pc",  if_id_pc,  32'h0000_000C);
        chk("t1_last_pc4", if_id_pc4, 32'h0000_0010);

        // 2: ack while stall rises, then release
        step("t2_stall_ack", 1'b1, 1'b0, 32'h0, 1'b1, 32'hE3A0_1005);
        chk("t2_held_pc", if_id_pc, 32'h0000_000C);
        step("t2_stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t2_release", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t2_instr", if_id_instr, 32'hE3A0_1005);
        chk("t2_next_addr", imem_addr, 32'h0000_0014);

        // 3: flush while the fetch is outstanding
        step("t3_flush", 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
        chk("t3_old_addr", imem_addr, 32'h0000_0014);
        step("t3_wait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t3_drop_ack", 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("t3_new_addr", imem_addr, 32'h0000_0100);
        step("t3_noack", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t3_first", 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h100));
        chk("t3_first_pc", if_id_pc, 32'h0000_0100);

        // 4: flush and stall together with ack
        step("t4", 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h1234_5678);
        chk("t4_addr", imem_addr, 32'h0000_0200);

        // 5: PC wrap
        step("t5_redirect", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
        step("t5_wrap", 1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC));
        chk("t5_addr", imem_addr, 32'h0000_0000);
        chk("t5_pc4",  if_id_pc4, 32'h0000_0000);

        // random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            rand_step();
        end

        // 6: asynchronous reset while a request is open
        step("t6_ensure_fetch", 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0);
        step("t6_open", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        imem_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_all("t6_idle");
        step("t6_restart", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_addr", imem_addr, RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
